// File: rtl/serial_adder_if.sv
// Operand and result handshake bundle for the bit-serial adder.
// The slave modport is the adder side; master is the producer/consumer side.
interface serial_adder_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, sum, carry_out
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, sum, carry_out
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice (two HalfAdders and an OR)
// processes one bit per clock, LSB first, between two valid/ready handshakes.

module HalfAdder (
    input  logic a_i,
    input  logic b_i,
    output logic sum_o,
    output logic carry_o
);
    assign sum_o   = a_i ^ b_i;
    assign carry_o = a_i & b_i;
endmodule

// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// RUN   | one bit slice added per clock, LSB first
// DONE  | result held, out_valid high until out_ready
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] sum_next;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic ha0_s, ha0_c, fa_s, ha1_c, fa_c;
    logic accept, last_bit;

    HalfAdder u_ha0 (.a_i(sa_q[0]), .b_i(sb_q[0]), .sum_o(ha0_s), .carry_o(ha0_c));
    HalfAdder u_ha1 (.a_i(ha0_s),   .b_i(carry_q), .sum_o(fa_s),  .carry_o(ha1_c));
    assign fa_c = ha0_c | ha1_c;

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 is the LSB.
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign sum_next = fa_s;
        end else begin : g_sum_wn
            assign sum_next = {fa_s, sum_q[WIDTH-1:1]};
        end
    endgenerate

    assign accept   = (state_q == IDLE) && bus.in_valid;
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)  state_d = RUN;
            RUN:     if (last_bit)      state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
    end

    always_comb begin
        sa_d    = sa_q;
        sb_d    = sb_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        if (accept) begin
            sa_d    = bus.a;
            sb_d    = bus.b;
            sum_d   = '0;
            carry_d = 1'b0;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            sa_d    = sa_q >> 1;
            sb_d    = sb_q >> 1;
            sum_d   = sum_next;
            carry_d = fa_c;
            cnt_d   = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_q    <= '0;
            sb_q    <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.sum       = sum_q;
    assign bus.carry_out = carry_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit and a 1-bit instance share clock and reset.
module tb_serial_adder;
    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    serial_adder_if #(.WIDTH(8)) bus8 ();
    serial_adder_if #(.WIDTH(1)) bus1 ();

    serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_sum;
        logic       exp_c;
    } vec8_t;

    typedef struct {
        logic a;
        logic b;
        logic [1:0] exp_cs;
    } vec1_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Enters and leaves on a falling edge; full accept -> result -> handshake.
    task automatic run8(input string name, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] es, input logic ec);
        int cyc;
        bus8.a        = av;
        bus8.b        = bv;
        bus8.in_valid = 1'b1;
        chk({name, " in_ready idle"}, 32'(bus8.in_ready), 32'd1);
        @(negedge clk);
        bus8.in_valid = 1'b0;
        chk({name, " in_ready run"}, 32'(bus8.in_ready), 32'd0);
        cyc = 0;
        while (!bus8.out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk({name, " latency"}, 32'(cyc), 32'd8);
        chk({name, " sum"}, 32'(bus8.sum), 32'(es));
        chk({name, " carry"}, 32'(bus8.carry_out), 32'(ec));
        bus8.out_ready = 1'b1;
        @(negedge clk);
        bus8.out_ready = 1'b0;
        chk({name, " out_valid after hs"}, 32'(bus8.out_valid), 32'd0);
        chk({name, " in_ready after hs"}, 32'(bus8.in_ready), 32'd1);
    endtask

    task automatic run1(input string name, input logic av, input logic bv, input logic [1:0] ecs);
        int cyc;
        bus1.a        = av;
        bus1.b        = bv;
        bus1.in_valid = 1'b1;
        chk({name, " in_ready idle"}, 32'(bus1.in_ready), 32'd1);
        @(negedge clk);
        bus1.in_valid = 1'b0;
        cyc = 1;
        chk({name, " out_valid in run"}, 32'(bus1.out_valid), 32'd0);
        while (!bus1.out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({name, " latency"}, 32'(cyc), 32'd2);
        chk({name, " carry,sum"}, 32'({bus1.carry_out, bus1.sum}), 32'(ecs));
        bus1.out_ready = 1'b1;
        @(negedge clk);
        bus1.out_ready = 1'b0;
        chk({name, " out_valid after hs"}, 32'(bus1.out_valid), 32'd0);
    endtask

    vec8_t v8[5];
    vec1_t v1[4];

    initial begin
        int cyc;
        int seen;

        v8[0] = '{8'hFF, 8'h01, 8'h00, 1'b1};
        v8[1] = '{8'hA5, 8'h5A, 8'hFF, 1'b0};
        v8[2] = '{8'h00, 8'h00, 8'h00, 1'b0};
        v8[3] = '{8'h3C, 8'hC4, 8'h00, 1'b1};
        v8[4] = '{8'h7F, 8'h01, 8'h80, 1'b0};
        v1[0] = '{1'b0, 1'b0, 2'b00};
        v1[1] = '{1'b0, 1'b1, 2'b01};
        v1[2] = '{1'b1, 1'b0, 2'b01};
        v1[3] = '{1'b1, 1'b1, 2'b10};

        // Reset with random inputs on both instances
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus8.in_valid  = 1'($urandom);
            bus8.out_ready = 1'($urandom);
            bus8.a         = 8'($urandom);
            bus8.b         = 8'($urandom);
            bus1.in_valid  = 1'($urandom);
            bus1.out_ready = 1'($urandom);
            bus1.a         = 1'($urandom);
            bus1.b         = 1'($urandom);
            @(negedge clk);
            chk("rst in_ready", 32'(bus8.in_ready), 32'd1);
            chk("rst out_valid", 32'(bus8.out_valid), 32'd0);
            chk("rst sum", 32'(bus8.sum), 32'd0);
            chk("rst carry", 32'(bus8.carry_out), 32'd0);
            chk("rst w1 out_valid", 32'(bus1.out_valid), 32'd0);
        end
        bus8.in_valid  = 1'b0;
        bus8.out_ready = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.out_ready = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++)
            run8($sformatf("w8 vec%0d", i), v8[i].a, v8[i].b, v8[i].exp_sum, v8[i].exp_c);

        // Backpressure: result must hold while out_ready stays low
        bus8.a = 8'h80; bus8.b = 8'h80; bus8.in_valid = 1'b1;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        cyc = 0;
        while (!bus8.out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("bp latency", 32'(cyc), 32'd8);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp out_valid held", 32'(bus8.out_valid), 32'd1);
            chk("bp sum held", 32'(bus8.sum), 32'h00);
            chk("bp carry held", 32'(bus8.carry_out), 32'd1);
            chk("bp in_ready low", 32'(bus8.in_ready), 32'd0);
        end
        bus8.out_ready = 1'b1;
        @(negedge clk);
        bus8.out_ready = 1'b0;
        chk("bp release out_valid", 32'(bus8.out_valid), 32'd0);
        chk("bp release in_ready", 32'(bus8.in_ready), 32'd1);

        // in_valid toggled during RUN must not be captured
        bus8.a = 8'h01; bus8.b = 8'h01; bus8.in_valid = 1'b1;
        @(negedge clk);
        bus8.a = 8'h12;
        cyc = 0;
        while (!bus8.out_valid && cyc < 40) begin
            bus8.in_valid = ~bus8.in_valid;
            @(negedge clk);
            cyc++;
        end
        bus8.in_valid = 1'b0;
        chk("ign latency", 32'(cyc), 32'd8);
        chk("ign sum", 32'(bus8.sum), 32'h02);
        chk("ign carry", 32'(bus8.carry_out), 32'd0);
        bus8.out_ready = 1'b1;
        @(negedge clk);
        bus8.out_ready = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus8.out_valid) seen++;
        end
        chk("ign single result", 32'(seen), 32'd0);
        chk("ign in_ready", 32'(bus8.in_ready), 32'd1);

        // Reset in the middle of RUN discards the operation
        bus8.a = 8'h55; bus8.b = 8'h0A; bus8.in_valid = 1'b1;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst in_ready", 32'(bus8.in_ready), 32'd1);
        chk("midrst sum", 32'(bus8.sum), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus8.out_valid) seen++;
        end
        chk("midrst no result", 32'(seen), 32'd0);
        run8("after rst", 8'h03, 8'h04, 8'h07, 1'b0);

        for (int i = 0; i < 4; i++)
            run1($sformatf("w1 vec%0d", i), v1[i].a, v1[i].b, v1[i].exp_cs);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder built around the existing `HalfAdder` cell. Two `HalfAdder` instances and an OR gate form a full adder, and a carry flip-flop sits between bit slices. The block accepts an operand pair over a valid/ready handshake and processes one bit per clock, LSB first. It then presents `{carry_out, sum} = a + b` over a second valid/ready handshake. It sits downstream of operand producers and upstream of any result consumer, trading latency for a single-bit datapath.

## Interface
- `WIDTH`, default 8: operand and sum width in bits. Legal range ≥ 1.
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: the operand pair on `a`/`b` is valid.
- `in_ready`, output, 1: the block can accept operands. High only in IDLE.
- `a`, input, WIDTH: operand A. Sampled on the accept edge only.
- `b`, input, WIDTH: operand B. Sampled on the accept edge only.
- `out_valid`, output, 1: `sum`/`carry_out` hold a complete result. High only in DONE.
- `out_ready`, input, 1: the consumer takes the result.
- `sum`, output, WIDTH: result bits [WIDTH-1:0].
- `carry_out`, output, 1: result bit WIDTH, i.e. the final carry.

## Operation
- Registers: operand shift registers `sa` and `sb` (WIDTH each), `sum` shift register, `carry` flop, bit counter (`$clog2(WIDTH)+1` bits), and a 2-bit state.
- State IDLE:
  - `in_ready` = 1.
  - On `in_valid && in_ready`: load `sa`=`a` and `sb`=`b`, clear `carry`, `sum`, and the counter, then go to RUN.
- State RUN: every cycle, with `{c, s} = FA(sa[0], sb[0], carry)`:
  - `sum <= {s, sum[WIDTH-1:1]}`.
  - `carry <= c`.
  - `sa` and `sb` shift right by 1.
  - counter increments.
  - When counter == WIDTH-1, go to DONE after this update.
- State DONE:
  - `out_valid` = 1.
  - `sum` and `carry_out` are frozen.
  - On `out_ready`, go to IDLE next edge.
  - Stays in DONE indefinitely while `out_ready` is 0.
- `carry_out` is driven directly from the `carry` flop.
- `in_valid` is ignored outside IDLE. Operands presented then are not captured.
- `out_ready` is ignored outside DONE.
- `sum`/`carry_out` are meaningful only while `out_valid` is high. They change during RUN.
- Arithmetic is modulo 2^(WIDTH+1). Unsigned interpretation. No overflow flag beyond `carry_out`.
- WIDTH=1: RUN lasts exactly one cycle, and the result equals the `HalfAdder` truth table with carry-in 0.
- Reset (`rst_n` low, at any time, including mid-RUN or in DONE):
  - Immediately forces state=IDLE and clears all registers.
  - Any in-flight operation is discarded and no result is emitted.
- Reset values:
  - `in_ready` = 1.
  - `out_valid` = 0.
  - `sum` = 0.
  - `carry_out` = 0.

## Timing
- Accept on edge E0 (in IDLE with `in_valid`=1).
- RUN occupies edges E1..E_WIDTH.
- `out_valid` rises after edge E_WIDTH, so the result is visible WIDTH cycles after the accept edge.
- Result handshake completes on the first edge with `out_valid && out_ready`. The block is back in IDLE after that edge, with `out_valid`=0 and `in_ready`=1.
- Minimum initiation interval is WIDTH+2 cycles: accept, WIDTH RUN cycles, then a DONE cycle with `out_ready`=1.
- `in_ready` and `out_valid` are pure functions of state. There is no combinational path from `in_valid` or `out_ready` to any output.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with random inputs → `in_ready`=1, `out_valid`=0, `sum`=0, `carry_out`=0 throughout.
- WIDTH=8:
  - a=8'hFF, b=8'h01 → exactly 8 cycles after accept, `out_valid`=1 with `sum`=8'h00 and `carry_out`=1.
  - a=8'hA5, b=8'h5A → `sum`=8'hFF, `carry_out`=0.
  - a=8'h00, b=8'h00 → `sum`=0, `carry_out`=0.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` rises (a=8'h80, b=8'h80) → `sum`=8'h00 and `carry_out`=1 stay stable, and `in_ready`=0. Raise `out_ready` → next cycle `out_valid`=0 and `in_ready`=1.
- Ignored input: toggle `in_valid` with a=8'h12 during RUN of 8'h01+8'h01 → result is 8'h02 with carry 0, and only one result is produced.
- Reset mid-operation: assert `rst_n`=0 at cycle 4 of RUN → `out_valid` never asserts for that pair. After release, 8'h03+8'h04 → `sum`=8'h07.
- WIDTH=1 instance: all four input pairs 00/01/10/11 → `{carry_out, sum}` = 00/01/01/10, each with `out_valid` 1 cycle after accept.
